// File: rtl/preg_pkg.sv
// Shared types for the multi-port program register file.
// Default widths and the write-port bundle used by the datapath.
package preg_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef logic [DEF_DATA_WIDTH-1:0] data_t;
    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

    typedef struct packed {
        logic  en;
        addr_t addr;
        data_t data;
    } wr_port_t;

endpackage

// File: rtl/preg_rd_port.sv
// One combinational read port: write bypass, zero register and
// busy qualification on top of the stored value.
module preg_rd_port #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] reg_data,
    input  logic                  reg_busy,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] wa0,
    input  logic [DATA_WIDTH-1:0] wd0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] wa1,
    input  logic [DATA_WIDTH-1:0] wd1,
    input  logic                  rsv_en,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  busy
);

    logic is_zero;
    logic hit0;
    logic hit1;
    logic rsv_hit;

    assign is_zero = ZERO_REG && (addr == '0);
    assign hit0    = BYPASS && we0 && (wa0 == addr);
    assign hit1    = BYPASS && we1 && (wa1 == addr);
    assign rsv_hit = rsv_en && (rsv_addr == addr);

    always_comb begin
        data = reg_data;
        if (rst || is_zero) begin
            data = '0;
        end else if (hit1) begin
            data = wd1;
        end else if (hit0) begin
            data = wd0;
        end
    end

    // A reserve landing with the write keeps the register pending.
    always_comb begin
        busy = reg_busy;
        if (rst || is_zero) begin
            busy = 1'b0;
        end else if ((hit0 || hit1) && !rsv_hit) begin
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/preg_mp.sv
// Multi-port program register file: NUM_RD read ports, two write
// ports, optional bypass and zero register, busy scoreboard.
module preg_mp
    import preg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RD     = 3,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         we0,
    input  logic [ADDR_WIDTH-1:0]        wa0,
    input  logic [DATA_WIDTH-1:0]        wd0,
    input  logic                         we1,
    input  logic [ADDR_WIDTH-1:0]        wa1,
    input  logic [DATA_WIDTH-1:0]        wd1,
    input  logic                         rsv_en,
    input  logic [ADDR_WIDTH-1:0]        rsv_addr
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;
    logic                  keep0;
    logic                  keep1;
    logic                  rsv_ok;

    assign keep0  = we0 && !(ZERO_REG && (wa0 == '0));
    assign keep1  = we1 && !(ZERO_REG && (wa1 == '0));
    assign rsv_ok = rsv_en && !(ZERO_REG && (rsv_addr == '0));

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (keep0) begin
                regs[wa0] <= wd0;
            end
            if (keep1) begin
                regs[wa1] <= wd1;
            end
        end
    end

    always_comb begin
        busy_nxt = busy;
        if (we0) begin
            busy_nxt[wa0] = 1'b0;
        end
        if (we1) begin
            busy_nxt[wa1] = 1'b0;
        end
        if (rsv_ok) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (clr) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;

        assign addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

        preg_rd_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .ZERO_REG  (ZERO_REG),
            .BYPASS    (BYPASS)
        ) u_port (
            .rst     (rst),
            .addr    (addr),
            .reg_data(regs[addr]),
            .reg_busy(busy[addr]),
            .we0     (we0),
            .wa0     (wa0),
            .wd0     (wd0),
            .we1     (we1),
            .wa1     (wa1),
            .wd1     (wd1),
            .rsv_en  (rsv_en),
            .rsv_addr(rsv_addr),
            .data    (rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .busy    (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_preg_mp.sv
// Bench for preg_mp: directed scenarios on a bypass and a no-bypass
// build, then a random run against a reference model.
module tb_preg_mp;
    import preg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [19:0] rd_addr;
    wr_port_t    w0;
    wr_port_t    w1;
    logic        rsv_en;
    addr_t       rsv_addr;
    logic [31:0] data_b;
    logic [31:0] data_n;
    logic [3:0]  busy_b;
    logic [3:0]  busy_n;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem_m [32];
    logic [31:0] busy_m;

    always #5 clk = ~clk;

    preg_mp #(.NUM_RD(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst), .clr(clr), .rd_addr(rd_addr),
        .rd_data(data_b), .rd_busy(busy_b),
        .we0(w0.en), .wa0(w0.addr), .wd0(w0.data),
        .we1(w1.en), .wa1(w1.addr), .wd1(w1.data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    preg_mp #(.NUM_RD(4), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nob (
        .clk(clk), .rst(rst), .clr(clr), .rd_addr(rd_addr),
        .rd_data(data_n), .rd_busy(busy_n),
        .we0(w0.en), .wa0(w0.addr), .wd0(w0.data),
        .we1(w1.en), .wa1(w1.addr), .wd1(w1.data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic wr_port_t wp(input int a, input int d);
        wr_port_t w;
        w.en   = 1'b1;
        w.addr = addr_t'(a);
        w.data = data_t'(d);
        return w;
    endfunction

    task automatic idle();
        w0     = '0;
        w1     = '0;
        rsv_en = 1'b0;
        rsv_addr = '0;
        clr    = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
        rd_addr = {addr_t'(a3), addr_t'(a2), addr_t'(a1), addr_t'(a0)};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] exp_rd(input bit byp, input addr_t a);
        logic [7:0] d;
        logic       b;
        logic       hit;
        if (a == '0) return 9'd0;
        d = mem_m[a];
        b = busy_m[a];
        hit = 1'b0;
        if (byp && w0.en && w0.addr == a) begin d = w0.data; hit = 1'b1; end
        if (byp && w1.en && w1.addr == a) begin d = w1.data; hit = 1'b1; end
        if (hit && !(rsv_en && rsv_addr == a)) b = 1'b0;
        return {b, d};
    endfunction

    task automatic model_commit();
        if (clr) begin
            for (int i = 0; i < 32; i++) mem_m[i] = '0;
            busy_m = '0;
        end else begin
            if (w0.en && w0.addr != '0) mem_m[w0.addr] = w0.data;
            if (w1.en && w1.addr != '0) mem_m[w1.addr] = w1.data;
            if (w0.en) busy_m[w0.addr] = 1'b0;
            if (w1.en) busy_m[w1.addr] = 1'b0;
            if (rsv_en && rsv_addr != '0) busy_m[rsv_addr] = 1'b1;
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        set_rd(3, 3, 3, 3);
        #2;
        check("rst_data_b", data_b, 32'h0);
        check("rst_data_n", data_n, 32'h0);
        check("rst_busy_b", {28'h0, busy_b}, 32'h0);
        w0 = wp(3, 8'hA5);
        #1;
        check("rst_no_bypass", data_b, 32'h0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        tick();

        // write r3, then async reset mid-cycle
        w0 = wp(3, 8'hA5);
        @(negedge clk);
        check("wr_same_byp", data_b, 32'hA5A5A5A5);
        check("wr_same_nob", data_n, 32'h0);
        tick();
        idle();
        @(negedge clk);
        check("wr_next_nob", data_n, 32'hA5A5A5A5);
        #1 rst = 1'b1;
        #1;
        check("arst_data_b", data_b, 32'h0);
        check("arst_data_n", data_n, 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("arst_after", data_b, 32'h0);
        check("arst_busy", {28'h0, busy_b, busy_n}, 32'h0);

        // dual write collision on r7
        tick();
        set_rd(7, 7, 7, 7);
        w0 = wp(7, 8'h11);
        w1 = wp(7, 8'h22);
        @(negedge clk);
        check("coll_same_byp", data_b, 32'h22222222);
        check("coll_same_nob", data_n, 32'h0);
        tick();
        idle();
        @(negedge clk);
        check("coll_next_b", data_b, 32'h22222222);
        check("coll_next_n", data_n, 32'h22222222);

        // zero register
        tick();
        set_rd(0, 0, 0, 0);
        w0 = wp(0, 8'hFF);
        w1 = wp(0, 8'hFF);
        @(negedge clk);
        check("zero_same_b", data_b, 32'h0);
        tick();
        idle();
        @(negedge clk);
        check("zero_next_b", data_b, 32'h0);
        check("zero_next_n", data_n, 32'h0);

        // one-cycle latency without bypass
        tick();
        set_rd(4, 4, 4, 4);
        w0 = wp(4, 8'h3C);
        @(negedge clk);
        check("lat_same_n", data_n, 32'h0);
        check("lat_same_b", data_b, 32'h3C3C3C3C);
        tick();
        idle();
        @(negedge clk);
        check("lat_next_n", data_n, 32'h3C3C3C3C);

        // scoreboard on r5
        tick();
        set_rd(5, 5, 5, 5);
        rsv_en = 1'b1;
        rsv_addr = 5'd5;
        @(negedge clk);
        check("rsv_same", {28'h0, busy_b}, 32'h0);
        tick();
        idle();
        @(negedge clk);
        check("rsv_next_b", {28'h0, busy_b}, 32'hF);
        check("rsv_next_n", {28'h0, busy_n}, 32'hF);
        tick();
        w0 = wp(5, 8'h09);
        @(negedge clk);
        check("wclr_same_b", {28'h0, busy_b}, 32'h0);
        check("wclr_same_n", {28'h0, busy_n}, 32'hF);
        check("wclr_data_b", data_b, 32'h09090909);
        tick();
        idle();
        @(negedge clk);
        check("wclr_next", {24'h0, busy_b, busy_n}, 32'h0);
        check("wclr_data_n", data_n, 32'h09090909);
        tick();
        w0 = wp(5, 8'h0A);
        rsv_en = 1'b1;
        rsv_addr = 5'd5;
        tick();
        idle();
        @(negedge clk);
        check("rsvw_busy", {24'h0, busy_b, busy_n}, 32'hFF);
        check("rsvw_data", data_n, 32'h0A0A0A0A);
        tick();
        w0 = wp(5, 8'h0B);
        rsv_en = 1'b1;
        rsv_addr = 5'd5;
        @(negedge clk);
        check("rsvw_same_b", {28'h0, busy_b}, 32'hF);
        tick();
        idle();
        @(negedge clk);
        check("rsvw2_busy", {28'h0, busy_n}, 32'hF);
        check("rsvw2_data", data_n, 32'h0B0B0B0B);

        // fill, reserve r2, then clear
        for (int i = 1; i < 32; i++) begin
            tick();
            w0 = wp(i, i);
        end
        tick();
        idle();
        rsv_en = 1'b1;
        rsv_addr = 5'd2;
        tick();
        idle();
        set_rd(1, 2, 16, 31);
        @(negedge clk);
        check("fill_data", data_n, 32'h1F100201);
        check("fill_busy", {28'h0, busy_n}, 32'h2);
        tick();
        clr = 1'b1;
        w0 = wp(1, 8'h55);
        tick();
        idle();
        @(negedge clk);
        check("clr_data_b", data_b, 32'h0);
        check("clr_data_n", data_n, 32'h0);
        check("clr_busy", {24'h0, busy_b, busy_n}, 32'h0);
        set_rd(5, 2, 7, 3);
        #1;
        check("clr_busy_r5", {24'h0, busy_b, busy_n}, 32'h0);

        // random regression against the model
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        busy_m = '0;
        for (int c = 0; c < 10000; c++) begin
            tick();
            w0.en    = ($urandom_range(0, 1) == 1);
            w0.addr  = addr_t'($urandom);
            w0.data  = data_t'($urandom);
            w1.en    = ($urandom_range(0, 2) == 0);
            w1.addr  = ($urandom_range(0, 3) == 0) ? w0.addr : addr_t'($urandom);
            w1.data  = data_t'($urandom);
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = ($urandom_range(0, 3) == 0) ? w0.addr : addr_t'($urandom);
            clr      = ($urandom_range(0, 63) == 0);
            rd_addr  = 20'($urandom);
            if ($urandom_range(0, 1) == 1) rd_addr[4:0] = w0.addr;
            if ($urandom_range(0, 1) == 1) rd_addr[9:5] = w1.addr;
            @(negedge clk);
            for (int p = 0; p < 4; p++) begin
                check("rnd_byp", {23'h0, busy_b[p], data_b[p*8 +: 8]},
                      {23'h0, exp_rd(1'b1, rd_addr[p*5 +: 5])});
                check("rnd_nob", {23'h0, busy_n[p], data_n[p*8 +: 8]},
                      {23'h0, exp_rd(1'b0, rd_addr[p*5 +: 5])});
            end
            model_commit();
        end
        tick();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
